// File: rtl/frame_sequencer_pkg.sv
// Shared frame geometry globals and the sequencer state encoding.
// Defines are guarded so a surrounding build can override them.
`ifndef FRAME_WIDTH
`define FRAME_WIDTH 8
`endif
`ifndef FRAME_HEIGHT
`define FRAME_HEIGHT 4
`endif
`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif
`ifndef SEQ_LATENCY
`define SEQ_LATENCY(w) ((w) + 2)
`endif

package frame_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_ACTIVE = 2'd1,
        SEQ_FLUSH  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/frame_sequencer_if.sv
// Upstream valid/ready pixel stream feeding the frame sequencer.
interface frame_sequencer_if #(
    parameter int PIXEL_SIZE = `PIXEL_SIZE
);
    logic                  in_valid;
    logic [PIXEL_SIZE-1:0] in_data;
    logic                  in_ready;

    modport master (output in_valid, in_data, input in_ready);
    modport slave  (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/frame_sequencer_raster_counter.sv
// Raster-order (x, y) counter with synchronous clear; last flags the final pixel.
module raster_counter #(
    parameter int W = 8,
    parameter int H = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 inc,
    output logic [$clog2(W)-1:0] x,
    output logic [$clog2(H)-1:0] y,
    output logic                 last
);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam logic [XW-1:0] X_LAST = XW'(W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

    logic x_last;
    assign x_last = (x == X_LAST);
    assign last   = x_last && (y == Y_LAST);

    // NOTE: nonblocking assignments so x and y both update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            if (x_last) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end
endmodule

// File: rtl/frame_sequencer.sv
// Feeds one gap-free frame into the pixel pipeline, flushes it with zeros,
// and tags the delayed pipeline output with its raster coordinate.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int FRAME_WIDTH  = `FRAME_WIDTH,
    parameter int FRAME_HEIGHT = `FRAME_HEIGHT,
    parameter int LATENCY      = `SEQ_LATENCY(FRAME_WIDTH)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    frame_sequencer_if.slave                up,
    output logic [`PIXEL_SIZE-1:0]          pix_data,
    output logic                            pix_en,
    output logic                            pix_hsync,
    output logic                            pix_vsync,
    output logic                            out_valid,
    output logic [$clog2(FRAME_WIDTH)-1:0]  out_x,
    output logic [$clog2(FRAME_HEIGHT)-1:0] out_y,
    output logic                            out_border,
    output logic                            busy,
    output logic                            done,
    output logic                            underrun
);
    localparam int XW = $clog2(FRAME_WIDTH);
    localparam int YW = $clog2(FRAME_HEIGHT);
    localparam int LW = $clog2(LATENCY + 1);
    localparam logic [XW-1:0] X_LAST  = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(FRAME_HEIGHT - 1);
    localparam logic [LW-1:0] LAG_MAX = LW'(LATENCY);

    seq_state_t    state;
    logic [LW-1:0] lag;
    logic [XW-1:0] in_x;
    logic [YW-1:0] in_y;
    logic          in_last;
    logic          out_last;
    logic          active;

    raster_counter #(.W(FRAME_WIDTH), .H(FRAME_HEIGHT)) u_in_cnt (
        .clk(clk), .reset_n(reset_n), .clr(state == SEQ_IDLE), .inc(active),
        .x(in_x), .y(in_y), .last(in_last)
    );

    raster_counter #(.W(FRAME_WIDTH), .H(FRAME_HEIGHT)) u_out_cnt (
        .clk(clk), .reset_n(reset_n), .clr(state == SEQ_IDLE), .inc(out_valid),
        .x(out_x), .y(out_y), .last(out_last)
    );

    // Pixel-side signals decode the registered state directly, so the pixel
    // accepted in a cycle is on pix_data in that same cycle.
    assign active      = (state == SEQ_ACTIVE);
    assign busy        = (state != SEQ_IDLE);
    assign up.in_ready = active;
    assign pix_en      = active;
    assign pix_data    = (active && up.in_valid) ? up.in_data : '0;
    assign pix_hsync   = active && (in_x == X_LAST) && (in_y != Y_LAST);
    assign pix_vsync   = active && in_last;

    assign out_valid  = busy && (lag == LAG_MAX);
    assign out_border = out_valid && ((out_x == '0) || (out_x == X_LAST) ||
                                      (out_y == '0) || (out_y == Y_LAST));

    // The last tagged result coincides with the final flush cycle, so the
    // output counter doubles as the flush length counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= SEQ_IDLE;
            lag      <= '0;
            underrun <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    lag <= '0;
                    if (start) begin
                        state    <= SEQ_ACTIVE;
                        underrun <= 1'b0;
                    end
                end
                SEQ_ACTIVE: begin
                    if (!up.in_valid) underrun <= 1'b1;
                    if (in_last)      state    <= SEQ_FLUSH;
                end
                SEQ_FLUSH: begin
                    if (out_valid && out_last) begin
                        state <= SEQ_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
            if (state != SEQ_IDLE && lag != LAG_MAX) lag <= lag + 1'b1;
        end
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized bench for frame_sequencer; expectations come from per-frame
// cycle offsets (k = cycle - first pixel cycle) computed arithmetically.
`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif
module tb_frame_sequencer;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int L  = 10;
    localparam int N  = W * H;
    localparam int PW = `PIXEL_SIZE;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] pix_data;
    logic          pix_en, pix_hsync, pix_vsync, out_valid;
    logic [2:0]    out_x;
    logic [1:0]    out_y;
    logic          out_border, busy, done, underrun;

    frame_sequencer_if #(.PIXEL_SIZE(PW)) bus ();

    frame_sequencer #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .up(bus),
        .pix_data(pix_data), .pix_en(pix_en), .pix_hsync(pix_hsync),
        .pix_vsync(pix_vsync), .out_valid(out_valid), .out_x(out_x),
        .out_y(out_y), .out_border(out_border), .busy(busy), .done(done),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit have  = 1'b0;   // model: a frame has been started
    int c0    = 0;      // model: first pixel cycle of that frame
    bit und   = 1'b0;   // model: sticky underrun
    int last_done = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic compare_cycle();
        int k  = cyc - c0;
        int ko = k - L;
        bit act = have && k >= 0 && k < N;
        bit bsy = have && k >= 0 && k < N + L;
        bit ov  = have && k >= L && k < N + L;
        bit dn  = have && k == N + L;
        logic [PW-1:0] exp_pix = (act && bus.in_valid) ? bus.in_data : '0;
        check("in_ready", bus.in_ready, act);
        check("pix_en", pix_en, act);
        check("pix_data", pix_data, exp_pix);
        check("hsync", pix_hsync, act && (k % W == W - 1) && (k / W < H - 1));
        check("vsync", pix_vsync, act && (k == N - 1));
        check("busy", busy, bsy);
        check("done", done, dn);
        check("underrun", underrun, und);
        check("out_valid", out_valid, ov);
        check("out_border", out_border, ov && ((ko % W == 0) || (ko % W == W - 1) ||
                                               (ko / W == 0) || (ko / W == H - 1)));
        if (ov) begin
            check("out_x", out_x, ko % W);
            check("out_y", out_y, ko / W);
        end
        if (done === 1'b1) last_done = cyc;
    endtask

    task automatic advance_model();
        int k   = cyc - c0;
        bit bsy = have && k >= 0 && k < N + L;
        if (!reset_n) begin
            have = 1'b0;
            und  = 1'b0;
        end else begin
            if (have && k >= 0 && k < N && !bus.in_valid) und = 1'b1;
            if (!bsy && start) begin
                have = 1'b1;
                c0   = cyc + 1;
                und  = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        advance_model();
        cyc++;
        #1;
    endtask

    initial begin
        int f0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // Clean frame: done exactly N+L cycles after the first pixel.
        start = 1'b1; bus.in_valid = 1'b1; tick(); start = 1'b0;
        f0 = c0;
        repeat (50) begin bus.in_data = PW'($urandom); tick(); end
        check("done_at_clean", last_done - f0, N + L);

        // Underrun: one missing pixel at k = 5.
        start = 1'b1; tick(); start = 1'b0;
        repeat (50) begin
            bus.in_valid = (cyc - c0 != 5);
            bus.in_data  = PW'($urandom);
            tick();
        end
        bus.in_valid = 1'b1;
        repeat (4) tick();

        // Next start clears underrun; a start at k = 20 is ignored.
        start = 1'b1; tick(); start = 1'b0;
        f0 = c0;
        repeat (50) begin
            start = (cyc - c0 == 20);
            bus.in_data = PW'($urandom);
            tick();
        end
        start = 1'b0;
        check("done_at_ignored_start", last_done - f0, N + L);
        repeat (10) tick();

        // Back-to-back frames with start held high.
        start = 1'b1;
        repeat (3 * (N + L + 1) + 2) begin bus.in_data = PW'($urandom); tick(); end
        start = 1'b0;
        repeat (50) tick();

        // Reset in the middle of a frame.
        start = 1'b1; tick(); start = 1'b0;
        repeat (12) begin bus.in_data = PW'($urandom); tick(); end
        #1 reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_pix_en", pix_en, 1'b0);
        check("rst_pix_data", pix_data, '0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_xy", {out_x, out_y}, '0);
        check("rst_done", done, 1'b0);
        have = 1'b0;
        und  = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        f0 = c0;
        repeat (50) begin bus.in_data = PW'($urandom); tick(); end
        check("done_at_after_reset", last_done - f0, N + L);

        // Random traffic: sparse starts, occasional missing pixels.
        repeat (400) begin
            start        = ($urandom_range(0, 19) == 0);
            bus.in_valid = ($urandom_range(0, 9) != 0);
            bus.in_data  = PW'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
